// File: rtl/fetch_prefetch_if.sv
// Fetch-side handshakes: bus request/response and the decode-facing output.
// master = fetch_prefetch, slave = busio/decode environment.
interface fetch_prefetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] next_pc_out;
    logic [31:0] instruction_out;

    modport master (
        output req_valid, req_address,
        input  req_ready, rsp_valid, rsp_data,
        output out_valid, pc_out, next_pc_out, instruction_out,
        input  out_ready
    );

    modport slave (
        input  req_valid, req_address,
        output req_ready, rsp_valid, rsp_data,
        input  out_valid, pc_out, next_pc_out, instruction_out,
        output out_ready
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: PC tag FIFO for in-flight reads plus a decode queue.
// Define FETCH_PERF_COUNTERS_EN to build the redirect/starve counters.
module fetch_prefetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int          DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    branch,
    input  logic [31:0]             branch_vector,
    input  logic                    trap,
    input  logic [31:0]             trap_vector,
    input  logic                    mret,
    input  logic [31:0]             mret_vector,
    fetch_prefetch_if.master        fi,
    output logic [31:0]             perf_redirects,
    output logic [31:0]             perf_starve
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   tag_mem [DEPTH];
    logic [63:0]   q_mem [DEPTH];
    logic [AW-1:0] tag_wp, tag_rp, q_wp, q_rp;
    logic [CW-1:0] occ, outst, discard;
    logic [CW:0]   used;
    logic          redirect, rsp_ok, keep, req_fire, pop;
    logic [31:0]   redirect_vector;
    logic [63:0]   head;

    assign redirect = trap | mret | branch;

    always_comb begin
        redirect_vector = branch_vector;
        priority case (1'b1)
            trap:    redirect_vector = trap_vector;
            mret:    redirect_vector = mret_vector;
            default: redirect_vector = branch_vector;
        endcase
    end

    assign used         = {1'b0, occ} + {1'b0, outst};
    assign fi.req_valid = reset && !redirect && (used < DEPTH_W);
    assign fi.req_address = fetch_pc;
    assign req_fire     = fi.req_valid && fi.req_ready;
    assign rsp_ok       = fi.rsp_valid && (outst != '0);
    assign keep         = reset && !redirect && rsp_ok && (discard == '0);
    assign pop          = fi.out_valid && fi.out_ready;

    // Outputs read zero whenever the queue is empty, which also covers reset.
    assign head               = q_mem[q_rp];
    assign fi.out_valid       = (occ != '0);
    assign fi.pc_out          = fi.out_valid ? head[63:32] : 32'd0;
    assign fi.instruction_out = fi.out_valid ? head[31:0] : 32'd0;
    assign fi.next_pc_out     = fi.out_valid ? head[63:32] + 32'd4 : 32'd0;

    always_ff @(posedge clk) begin
        if (req_fire) tag_mem[tag_wp] <= fetch_pc;
        if (keep) q_mem[q_wp] <= {tag_mem[tag_rp], fi.rsp_data};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_VECTOR;
            occ      <= '0;
            outst    <= '0;
            discard  <= '0;
            tag_wp   <= '0;
            tag_rp   <= '0;
            q_wp     <= '0;
            q_rp     <= '0;
        end else if (redirect) begin
            // Everything still on the bus becomes garbage to be dropped.
            fetch_pc <= redirect_vector;
            occ      <= '0;
            tag_wp   <= '0;
            tag_rp   <= '0;
            q_wp     <= '0;
            q_rp     <= '0;
            outst    <= outst - CW'(rsp_ok);
            discard  <= outst - CW'(rsp_ok);
        end else begin
            if (req_fire) begin
                tag_wp   <= tag_wp + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (keep) begin
                q_wp   <= q_wp + 1'b1;
                tag_rp <= tag_rp + 1'b1;
            end
            if (rsp_ok && discard != '0) discard <= discard - 1'b1;
            if (pop) q_rp <= q_rp + 1'b1;
            outst <= outst + CW'(req_fire) - CW'(rsp_ok);
            occ   <= occ + CW'(keep) - CW'(pop);
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] redirects_q, starve_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            redirects_q <= '0;
            starve_q    <= '0;
        end else begin
            if (redirect) redirects_q <= redirects_q + 32'd1;
            if (fi.out_ready && !fi.out_valid) starve_q <= starve_q + 32'd1;
        end
    end

    assign perf_redirects = redirects_q;
    assign perf_starve    = starve_q;
`else
    assign perf_redirects = 32'd0;
    assign perf_starve    = 32'd0;
`endif
endmodule
